// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: hazard sources from the core (master) and the
// stall codes, PC strobes and perf counters returned by the controller (slave).
interface pipe_hazard_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic             ex_mem_rena;
   logic [4:0]       ex_rd_waddr;
   logic             ex_redirect;
   logic             if_busy;
   logic             mem_busy;
   logic             pc_stall;
   logic             pc_redirect;
   logic [1:0]       stall_if_id;
   logic [1:0]       stall_id_ex;
   logic [1:0]       stall_ex_mem;
   logic [1:0]       stall_mem_wb;
   logic             kill_pending;
   logic [CNT_W-1:0] cnt_load_use;
   logic [CNT_W-1:0] cnt_redirect;
   logic [CNT_W-1:0] cnt_mem_wait;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_mem_rena, ex_rd_waddr, ex_redirect, if_busy, mem_busy,
      input  pc_stall, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
             stall_mem_wb, kill_pending, cnt_load_use, cnt_redirect, cnt_mem_wait
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_mem_rena, ex_rd_waddr, ex_redirect, if_busy, mem_busy,
      output pc_stall, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
             stall_mem_wb, kill_pending, cnt_load_use, cnt_redirect, cnt_mem_wait
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core, with a RUN/KILL FSM that drops a stale fetch.
// Stall-cause performance counters are built only when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   pipe_hazard_if.slave  hz
);
   localparam logic [1:0] STALL_NEXT = 2'b00;
   localparam logic [1:0] STALL_KEEP = 2'b01;
   localparam logic [1:0] STALL_ZERO = 2'b10;

   typedef enum logic {RUN, KILL} state_e;
   state_e state_q, state_d;

   logic load_use;
   logic case_lu;

   assign load_use = hz.ex_mem_rena && (hz.ex_rd_waddr != 5'd0) &&
                     ((hz.id_rs1_used && hz.id_rs1_addr == hz.ex_rd_waddr) ||
                      (hz.id_rs2_used && hz.id_rs2_addr == hz.ex_rd_waddr));

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      hz.pc_stall     = 1'b0;
      hz.pc_redirect  = 1'b0;
      hz.stall_if_id  = STALL_NEXT;
      hz.stall_id_ex  = STALL_NEXT;
      hz.stall_ex_mem = STALL_NEXT;
      hz.stall_mem_wb = STALL_NEXT;
      case_lu         = 1'b0;
      // A held EX stage re-presents its redirect later, so mem_busy outranks it.
      if (hz.mem_busy) begin
         hz.pc_stall     = 1'b1;
         hz.stall_if_id  = STALL_KEEP;
         hz.stall_id_ex  = STALL_KEEP;
         hz.stall_ex_mem = STALL_KEEP;
         hz.stall_mem_wb = STALL_ZERO;
      end else if (hz.ex_redirect) begin
         hz.pc_redirect  = 1'b1;
         hz.stall_if_id  = STALL_ZERO;
         hz.stall_id_ex  = STALL_ZERO;
      end else if (load_use) begin
         case_lu         = 1'b1;
         hz.pc_stall     = 1'b1;
         hz.stall_if_id  = STALL_KEEP;
         hz.stall_id_ex  = STALL_ZERO;
      end else if (state_q == KILL || hz.if_busy) begin
         hz.pc_stall     = 1'b1;
         hz.stall_if_id  = STALL_ZERO;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:  if (hz.pc_redirect && hz.if_busy) state_d = KILL;
         KILL: if (!hz.if_busy) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   assign hz.kill_pending = (state_q == KILL);

`ifdef PIPE_PERF_EN
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [CNT_W-1:0] cnt_load_use_q, cnt_load_use_d;
   logic [CNT_W-1:0] cnt_redirect_q, cnt_redirect_d;
   logic [CNT_W-1:0] cnt_mem_wait_q, cnt_mem_wait_d;

   // Saturating: an overflowed counter stays pinned at all-ones.
   always_comb begin
      cnt_load_use_d = cnt_load_use_q;
      cnt_redirect_d = cnt_redirect_q;
      cnt_mem_wait_d = cnt_mem_wait_q;
      if (case_lu && cnt_load_use_q != '1)        cnt_load_use_d = cnt_load_use_q + ONE;
      if (hz.pc_redirect && cnt_redirect_q != '1) cnt_redirect_d = cnt_redirect_q + ONE;
      if (hz.mem_busy && cnt_mem_wait_q != '1)    cnt_mem_wait_d = cnt_mem_wait_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_load_use_q <= '0;
         cnt_redirect_q <= '0;
         cnt_mem_wait_q <= '0;
      end else begin
         cnt_load_use_q <= cnt_load_use_d;
         cnt_redirect_q <= cnt_redirect_d;
         cnt_mem_wait_q <= cnt_mem_wait_d;
      end
   end

   assign hz.cnt_load_use = cnt_load_use_q;
   assign hz.cnt_redirect = cnt_redirect_q;
   assign hz.cnt_mem_wait = cnt_mem_wait_q;
`else
   assign hz.cnt_load_use = '0;
   assign hz.cnt_redirect = '0;
   assign hz.cnt_mem_wait = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for single-cycle cases plus
// hand sequences for KILL, mem_busy hold, reset-in-KILL and the perf counters.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_if #(.CNT_W(32)) ifa ();
   pipe_hazard_if #(.CNT_W(2))  ifb ();

   pipe_hazard_ctrl #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));
   pipe_hazard_ctrl #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       rena;
      logic [4:0] rd;
      logic       redir;
      logic       ifbsy;
      logic       membsy;
   } vin_t;

   typedef struct packed {
      vin_t        vin;
      logic [10:0] exp;
   } vec_t;

   // {pc_stall, pc_redirect, if_id, id_ex, ex_mem, mem_wb, kill_pending}
   localparam logic [10:0] E_IDLE = 11'b0_0_00_00_00_00_0;
   localparam logic [10:0] E_LU   = 11'b1_0_01_10_00_00_0;
   localparam logic [10:0] E_RD   = 11'b0_1_10_10_00_00_0;
   localparam logic [10:0] E_IFB  = 11'b1_0_10_00_00_00_0;
   localparam logic [10:0] E_MEM  = 11'b1_0_01_01_01_10_0;
   localparam logic [10:0] E_KILL = 11'b1_0_10_00_00_00_1;
   localparam logic [10:0] E_RDK  = 11'b0_1_10_10_00_00_0;

   int nchk = 0;
   int nfail = 0;

   function automatic vin_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic rena, logic [4:0] rd, logic redir, logic ifbsy,
                               logic membsy);
      vin_t v;
      v = '{rs1, rs2, u1, u2, rena, rd, redir, ifbsy, membsy};
      return v;
   endfunction

   task automatic drive(vin_t v);
      ifa.id_rs1_addr = v.rs1;   ifb.id_rs1_addr = v.rs1;
      ifa.id_rs2_addr = v.rs2;   ifb.id_rs2_addr = v.rs2;
      ifa.id_rs1_used = v.u1;    ifb.id_rs1_used = v.u1;
      ifa.id_rs2_used = v.u2;    ifb.id_rs2_used = v.u2;
      ifa.ex_mem_rena = v.rena;  ifb.ex_mem_rena = v.rena;
      ifa.ex_rd_waddr = v.rd;    ifb.ex_rd_waddr = v.rd;
      ifa.ex_redirect = v.redir; ifb.ex_redirect = v.redir;
      ifa.if_busy     = v.ifbsy; ifb.if_busy     = v.ifbsy;
      ifa.mem_busy    = v.membsy; ifb.mem_busy   = v.membsy;
   endtask

   // Inputs change 1 time unit after the edge; checks happen mid-cycle.
   task automatic cyc(vin_t v);
      @(posedge clk);
      #1;
      drive(v);
      #3;
   endtask

   function automatic logic [10:0] outs_a();
      return {ifa.pc_stall, ifa.pc_redirect, ifa.stall_if_id, ifa.stall_id_ex,
              ifa.stall_ex_mem, ifa.stall_mem_wb, ifa.kill_pending};
   endfunction

   function automatic logic [10:0] outs_b();
      return {ifb.pc_stall, ifb.pc_redirect, ifb.stall_if_id, ifb.stall_id_ex,
              ifb.stall_ex_mem, ifb.stall_mem_wb, ifb.kill_pending};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_outs(string name, logic [10:0] exp);
      chk(name, {21'd0, outs_a()}, {21'd0, exp});
      chk({name, "_w2"}, {21'd0, outs_b()}, {21'd0, exp});
   endtask

   task automatic chk_cnt(string name, int lu, int rd, int mw);
      int lu_b, rd_b, mw_b;
`ifdef PIPE_PERF_EN
      lu_b = (lu > 3) ? 3 : lu;
      rd_b = (rd > 3) ? 3 : rd;
      mw_b = (mw > 3) ? 3 : mw;
`else
      lu = 0; rd = 0; mw = 0;
      lu_b = 0; rd_b = 0; mw_b = 0;
`endif
      chk({name, "_lu"},    ifa.cnt_load_use, lu);
      chk({name, "_rd"},    ifa.cnt_redirect, rd);
      chk({name, "_mw"},    ifa.cnt_mem_wait, mw);
      chk({name, "_lu_w2"}, {30'd0, ifb.cnt_load_use}, lu_b);
      chk({name, "_rd_w2"}, {30'd0, ifb.cnt_redirect}, rd_b);
      chk({name, "_mw_w2"}, {30'd0, ifb.cnt_mem_wait}, mw_b);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive('0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
   endtask

   vec_t tbl[12];
   vin_t idle;
   vin_t lu_rd_mem;

   initial begin
      idle = '0;
      drive(idle);
      tbl[0]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0), E_IDLE};
      tbl[1]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0), E_LU};
      tbl[2]  = '{mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0), E_IDLE};
      tbl[3]  = '{mk(5'd3, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0), E_LU};
      tbl[4]  = '{mk(5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0), E_IDLE};
      tbl[5]  = '{mk(5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 0), E_IDLE};
      tbl[6]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0), E_RD};
      tbl[7]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0), E_IFB};
      tbl[8]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 1), E_MEM};
      tbl[9]  = '{mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0), E_RD};
      tbl[10] = '{mk(5'd9, 5'd9, 1, 1, 1, 5'd9, 0, 1, 0), E_LU};
      tbl[11] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1), E_MEM};

      do_reset();
      chk_outs("reset_outs", E_IDLE);
      chk_cnt("reset_cnt", 0, 0, 0);

      // None of the table rows produce pc_redirect with if_busy, so state stays RUN.
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].vin);
         chk_outs($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Redirect with a fetch in flight, stale fetch returns after 3 busy cycles.
      do_reset();
      cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      chk_outs("kill_redir", E_RDK);
      for (int i = 0; i < 3; i++) begin
         cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
         chk_outs($sformatf("kill_busy%0d", i), E_KILL);
      end
      cyc(idle);
      chk_outs("kill_drop", E_KILL);
      cyc(idle);
      chk_outs("kill_back_run", E_IDLE);

      // mem_busy holds off both redirect and load-use; redirect taken afterwards.
      do_reset();
      lu_rd_mem = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(lu_rd_mem);
         chk_outs($sformatf("mem_hold%0d", i), E_MEM);
      end
      lu_rd_mem.membsy = 1'b0;
      cyc(lu_rd_mem);
      chk_outs("mem_release_redir", E_RD);

      // Counters: 4 mem_busy + 1 load-use + 2 redirects.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      cyc(mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0));
      cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      cyc(idle);
      chk_cnt("perf", 1, 2, 4);
      for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      cyc(idle);
      chk_cnt("perf_sat", 1, 5, 4);

      // Reset while in KILL.
      cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      chk_outs("pre_rst_kill", E_KILL);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(idle);
      #3;
      chk_outs("rst_in_kill", E_IDLE);
      chk_cnt("rst_in_kill_cnt", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end
endmodule
